// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage and its prefetch queue.
package fetch_unit_pkg;

  localparam int unsigned FETCH_DATA_WIDTH  = 32;
  localparam int unsigned FETCH_ADDR_WIDTH  = 16;
  localparam int unsigned FETCH_MAX_LATENCY = 4;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; flush beats any coincident push or pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !i_flush;
  assign do_pop  = i_pop && !i_flush && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with fixed-latency memory, prefetch queue and redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = FETCH_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           MEM_LATENCY = 1,
  parameter int unsigned           QUEUE_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic                  o_mem_req,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  if (MEM_LATENCY < 1 || MEM_LATENCY > FETCH_MAX_LATENCY) begin : g_bad_latency
    $error("fetch_unit: MEM_LATENCY out of range");
  end
  if (!is_pow2(QUEUE_DEPTH) || QUEUE_DEPTH < 2) begin : g_bad_depth
    $error("fetch_unit: QUEUE_DEPTH must be a power of 2 and >= 2");
  end

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]       credit_q, credit_d;
  logic [MEM_LATENCY-1:0] trk_vld_q, trk_vld_d;
  logic [ADDR_WIDTH-1:0]  trk_pc_q [MEM_LATENCY];
  logic [ADDR_WIDTH-1:0]  trk_pc_d [MEM_LATENCY];
  logic [ENTRY_W-1:0]     q_head;
  logic [CNT_W-1:0]       q_count;
  logic                   issue;
  logic                   push;
  logic                   pop;

  // Credit covers queued plus in-flight words, so the queue can never overflow.
  assign issue = i_rst && !i_redirect && (credit_q < CNT_W'(QUEUE_DEPTH));
  assign push  = trk_vld_q[MEM_LATENCY-1];
  assign pop   = o_valid && i_ready && !i_redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    credit_d   = credit_q;
    trk_vld_d  = trk_vld_q;
    trk_pc_d   = trk_pc_q;
    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      credit_d   = '0;
      trk_vld_d  = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      credit_d = credit_q + CNT_W'(issue) - CNT_W'(pop);
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        trk_vld_d[i] = trk_vld_q[i-1];
        trk_pc_d[i]  = trk_pc_q[i-1];
      end
      trk_vld_d[0] = issue;
      trk_pc_d[0]  = fetch_pc_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fetch_pc_q <= RESET_PC;
      credit_q   <= '0;
      trk_vld_q  <= '0;
      trk_pc_q   <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      credit_q   <= credit_d;
      trk_vld_q  <= trk_vld_d;
      trk_pc_q   <= trk_pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  ({trk_pc_q[MEM_LATENCY-1], i_mem_data}),
    .i_pop   (pop),
    .i_flush (i_redirect),
    .o_head  (q_head),
    .o_count (q_count)
  );

  assign o_mem_addr  = fetch_pc_q;
  assign o_mem_write = 1'b0;
  assign o_mem_req   = issue;
  assign o_valid     = (q_count != '0);
  assign o_inst      = o_valid ? q_head[DATA_WIDTH-1:0] : '0;
  assign o_pc        = o_valid ? q_head[ENTRY_W-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, PC wrap and mid-stream reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // DUT A: defaults, 16-bit PC
  logic        a_rst = 1'b0, a_ready = 1'b0, a_redir = 1'b0;
  logic [15:0] a_redir_pc = '0, a_addr, a_pc, a_pipe;
  logic [31:0] a_mdata, a_inst;
  logic        a_write, a_req, a_valid;

  always_ff @(posedge clk) a_pipe <= a_addr;
  assign a_mdata = 32'h100 + 32'(a_pipe);

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RESET_PC(16'h0),
               .MEM_LATENCY(1), .QUEUE_DEPTH(4)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .o_mem_addr(a_addr), .o_mem_write(a_write),
    .o_mem_req(a_req), .i_mem_data(a_mdata), .i_redirect(a_redir),
    .i_redirect_pc(a_redir_pc), .o_inst(a_inst), .o_pc(a_pc),
    .o_valid(a_valid), .i_ready(a_ready));

  // DUT B: 8-bit PC starting two below wrap
  logic        b_rst = 1'b0, b_ready = 1'b1;
  logic [7:0]  b_addr, b_pc, b_pipe;
  logic [31:0] b_mdata, b_inst;
  logic        b_write, b_req, b_valid;

  always_ff @(posedge clk) b_pipe <= b_addr;
  assign b_mdata = 32'h100 + 32'(b_pipe);

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_PC(8'hFE),
               .MEM_LATENCY(1), .QUEUE_DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .o_mem_addr(b_addr), .o_mem_write(b_write),
    .o_mem_req(b_req), .i_mem_data(b_mdata), .i_redirect(1'b0),
    .i_redirect_pc(8'h00), .o_inst(b_inst), .o_pc(b_pc),
    .o_valid(b_valid), .i_ready(b_ready));

  // DUT C: latency 3, depth 8
  logic        c_rst = 1'b0, c_ready = 1'b1;
  logic [15:0] c_addr, c_pc;
  logic [15:0] c_pipe [3];
  logic [31:0] c_mdata, c_inst;
  logic        c_write, c_req, c_valid;

  always_ff @(posedge clk) begin
    c_pipe[0] <= c_addr;
    c_pipe[1] <= c_pipe[0];
    c_pipe[2] <= c_pipe[1];
  end
  assign c_mdata = 32'h100 + 32'(c_pipe[2]);

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .RESET_PC(16'h0),
               .MEM_LATENCY(3), .QUEUE_DEPTH(8)) u_dut_c (
    .i_clk(clk), .i_rst(c_rst), .o_mem_addr(c_addr), .o_mem_write(c_write),
    .o_mem_req(c_req), .i_mem_data(c_mdata), .i_redirect(1'b0),
    .i_redirect_pc(16'h0), .o_inst(c_inst), .o_pc(c_pc),
    .o_valid(c_valid), .i_ready(c_ready));

  // Leaves the bench sampling in cycle 0 after A's reset release.
  task automatic start_a();
    a_rst   = 1'b0;
    a_redir = 1'b0;
    repeat (2) cyc();
    cyc();
    a_rst = 1'b1;
    #1;
  endtask

  initial begin
    int cnt;

    // Reset state
    #2;
    check_eq("rst_valid", 32'(a_valid), 32'd0);
    check_eq("rst_req",   32'(a_req),   32'd0);
    check_eq("rst_addr",  32'(a_addr),  32'h0);
    check_eq("rst_write", 32'(a_write), 32'd0);
    check_eq("rst_inst",  a_inst,       32'h0);
    check_eq("rst_pc",    32'(a_pc),    32'h0);

    // Streaming from reset with ready high
    a_ready = 1'b1;
    start_a();
    check_eq("s_c0_req",   32'(a_req),   32'd1);
    check_eq("s_c0_valid", 32'(a_valid), 32'd0);
    cyc(); #1;
    check_eq("s_c1_valid", 32'(a_valid), 32'd0);
    for (int k = 2; k < 10; k++) begin
      cyc(); #1;
      check_eq("s_valid", 32'(a_valid), 32'd1);
      check_eq("s_pc",    32'(a_pc),    32'(k - 2));
      check_eq("s_inst",  a_inst,       32'h100 + 32'(k - 2));
    end

    // Stalled consumer: exactly QUEUE_DEPTH requests, then drain in order
    a_ready = 1'b0;
    start_a();
    cnt = int'(a_req);
    for (int k = 1; k < 20; k++) begin
      cyc(); #1;
      cnt += int'(a_req);
    end
    check_eq("stall_reqs",  32'(cnt),     32'd4);
    check_eq("stall_req",   32'(a_req),   32'd0);
    check_eq("stall_valid", 32'(a_valid), 32'd1);
    check_eq("stall_pc",    32'(a_pc),    32'h0);
    cyc();
    a_ready = 1'b1;
    #1;
    check_eq("drain_req0", 32'(a_req), 32'd0);
    check_eq("drain_pc0",  32'(a_pc),  32'h0);
    for (int i = 1; i < 8; i++) begin
      cyc(); #1;
      check_eq("drain_valid", 32'(a_valid), 32'd1);
      check_eq("drain_pc",    32'(a_pc),    32'(i));
    end

    // Redirect with queued and in-flight fetches
    a_ready = 1'b0;
    start_a();
    repeat (3) cyc();
    a_redir = 1'b1;
    a_redir_pc = 16'h40;
    #1;
    check_eq("rd_t_req",   32'(a_req),   32'd0);
    check_eq("rd_t_valid", 32'(a_valid), 32'd1);
    cyc();
    a_redir = 1'b0;
    a_ready = 1'b1;
    #1;
    check_eq("rd_t1_valid", 32'(a_valid), 32'd0);
    check_eq("rd_t1_req",   32'(a_req),   32'd1);
    check_eq("rd_t1_addr",  32'(a_addr),  32'h40);
    cyc(); #1;
    check_eq("rd_t2_valid", 32'(a_valid), 32'd0);
    cyc(); #1;
    check_eq("rd_t3_valid", 32'(a_valid), 32'd1);
    check_eq("rd_t3_pc",    32'(a_pc),    32'h40);
    check_eq("rd_t3_inst",  a_inst,       32'h140);
    cyc(); #1;
    check_eq("rd_t4_pc",    32'(a_pc),    32'h41);

    // Redirect coincident with a pop, then a second redirect
    a_ready = 1'b1;
    start_a();
    repeat (4) cyc();
    check_eq("rr_pre_valid", 32'(a_valid), 32'd1);
    check_eq("rr_pre_pc",    32'(a_pc),    32'h2);
    a_redir = 1'b1;
    a_redir_pc = 16'h20;
    cyc();
    a_redir_pc = 16'h80;
    #1;
    check_eq("rr_2_valid", 32'(a_valid), 32'd0);
    check_eq("rr_2_req",   32'(a_req),   32'd0);
    cyc();
    a_redir = 1'b0;
    #1;
    check_eq("rr_t1_req",   32'(a_req),   32'd1);
    check_eq("rr_t1_addr",  32'(a_addr),  32'h80);
    check_eq("rr_t1_valid", 32'(a_valid), 32'd0);
    cyc(); #1;
    check_eq("rr_t2_valid", 32'(a_valid), 32'd0);
    cyc(); #1;
    check_eq("rr_t3_valid", 32'(a_valid), 32'd1);
    check_eq("rr_t3_pc",    32'(a_pc),    32'h80);
    cyc(); #1;
    check_eq("rr_t4_pc",    32'(a_pc),    32'h81);

    // PC wrap on DUT B
    cyc();
    b_rst = 1'b1;
    #1;
    check_eq("wr_c0_addr", 32'(b_addr), 32'hFE);
    cyc(); #1;
    check_eq("wr_c1_valid", 32'(b_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_pc;
      exp_pc = 8'hFE + 8'(k);
      cyc(); #1;
      check_eq("wr_valid", 32'(b_valid), 32'd1);
      check_eq("wr_pc",    32'(b_pc),    32'(exp_pc));
      check_eq("wr_inst",  b_inst,       32'h100 + 32'(exp_pc));
      check_eq("wr_write", 32'(b_write), 32'd0);
    end

    // Latency 3 / depth 8, with asynchronous reset mid-stream
    cyc();
    c_rst = 1'b1;
    #1;
    for (int k = 1; k < 4; k++) begin
      cyc(); #1;
      check_eq("l3_early_valid", 32'(c_valid), 32'd0);
    end
    for (int k = 4; k < 10; k++) begin
      cyc(); #1;
      check_eq("l3_valid", 32'(c_valid), 32'd1);
      check_eq("l3_pc",    32'(c_pc),    32'(k - 4));
    end
    #2;
    c_rst = 1'b0;
    #1;
    check_eq("ar_valid", 32'(c_valid), 32'd0);
    check_eq("ar_req",   32'(c_req),   32'd0);
    check_eq("ar_addr",  32'(c_addr),  32'h0);
    check_eq("ar_inst",  c_inst,       32'h0);
    check_eq("ar_pc",    32'(c_pc),    32'h0);
    repeat (2) cyc();
    c_rst = 1'b1;
    #1;
    check_eq("ar_c0_req", 32'(c_req), 32'd1);
    for (int k = 1; k < 4; k++) begin
      cyc(); #1;
      check_eq("ar_early_valid", 32'(c_valid), 32'd0);
    end
    cyc(); #1;
    check_eq("ar_c4_valid", 32'(c_valid), 32'd1);
    check_eq("ar_c4_pc",    32'(c_pc),    32'h0);
    check_eq("ar_c4_inst",  c_inst,       32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
